// File: rtl/arm_mc_ctrl_fsm.sv
// Main sequencing controller for the multicycle ARM datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and drives datapath enables and selects.
module arm_mc_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       cond_ex,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       flag_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state;

    logic is_cmp;
    logic dst_pc;

    assign is_cmp  = (funct[4:1] == 4'b1010);
    assign dst_pc  = (rd == 4'd15);
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore decode of the current state; instruction fields only gate the write enables.
    // A writeback that targets R15 is redirected into the PC instead of the register file.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        flag_write = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 1'b0;
        if (reset) begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
        end else begin
            case (state)
                FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                DECODE: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                MEMADR: alu_src_b = 2'b01;
                MEMRD:  adr_src = 1'b1;
                MEMWB: begin
                    result_src = 2'b01;
                    if (cond_ex) begin
                        pc_write  = dst_pc;
                        reg_write = !dst_pc;
                    end
                end
                MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = cond_ex;
                end
                EXECR: begin
                    alu_op     = 1'b1;
                    flag_write = funct[0] && cond_ex;
                end
                EXECI: begin
                    alu_src_b  = 2'b01;
                    alu_op     = 1'b1;
                    flag_write = funct[0] && cond_ex;
                end
                ALUWB: begin
                    if (cond_ex && !is_cmp) begin
                        pc_write  = dst_pc;
                        reg_write = !dst_pc;
                    end
                end
                BRANCH: begin
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = cond_ex;
                end
                default: ;
            endcase
        end
    end

endmodule
